// File: rtl/uart_bus_sched.sv
// uart_bus_sched: bus master for simple_uart's 4-register port.
// It programs the baud divider once after reset and then polls SR. Two
// byte-stream requesters share the transmitter by round-robin. Received
// bytes are drained into a one-entry valid/ready output.
// Optional feature macro: UART_SCHED_RX_EN enables the receive path (RDI/WIDR/CLR).
// Without it the rx outputs are tied low and only SR polling and ODR/BSR
// writes ever reach the UART.
// Bus outputs are registered as each state is entered, so the access named
// by a state is on the bus during that state's cycle. The UART's registered
// read data is therefore present in the cycle after the strobe (WSR, WIDR).
module uart_bus_sched #(
    parameter logic [31:0] BAUD_DIV = 32'd2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        u_sel_o,
    output logic        u_we_o,
    output logic [1:0]  u_addr_o,
    output logic [31:0] u_data_o,
    input  logic [31:0] u_data_i,
    input  logic        tx0_valid_i,
    input  logic [7:0]  tx0_data_i,
    output logic        tx0_ready_o,
    input  logic        tx1_valid_i,
    input  logic [7:0]  tx1_data_i,
    output logic        tx1_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_fe_o,
    input  logic        rx_ready_i,
    output logic        init_done_o
);

    typedef enum logic [3:0] {
        ST_INIT,
        ST_BSR,
        ST_POLL,
        ST_WSR,
        ST_RDI,
        ST_WIDR,
        ST_CLR,
        ST_WR,
        ST_GAP
    } state_t;

    localparam logic [1:0] A_ODR = 2'd0;
    localparam logic [1:0] A_IDR = 2'd1;
    localparam logic [1:0] A_BSR = 2'd2;
    localparam logic [1:0] A_SR  = 2'd3;

    state_t      r_state;
    logic        r_sel;
    logic        r_we;
    logic [1:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_rdy0;
    logic        r_rdy1;
    logic        r_rr_last;
    logic        r_init_done;

    logic        w_any_tx;
    logic        w_grant;
    logic [7:0]  w_grant_data;
    logic        w_sr_busy;

    // Grant channel 1 when it alone is valid, or when both are valid and
    // channel 0 was the last one served.
    assign w_any_tx     = tx0_valid_i | tx1_valid_i;
    assign w_grant      = tx1_valid_i & (~tx0_valid_i | ~r_rr_last);
    assign w_grant_data = w_grant ? tx1_data_i : tx0_data_i;
    assign w_sr_busy    = u_data_i[0];

`ifdef UART_SCHED_RX_EN
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic        r_rx_fe;
    logic        r_sr_fe;
    logic        w_sr_rx;
    logic        w_unused;

    assign w_sr_rx  = u_data_i[1];
    assign w_unused = ^u_data_i[31:8];

    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
    assign rx_fe_o    = r_rx_fe;
`else
    logic        w_unused;

    assign w_unused = ^{u_data_i[31:1], rx_ready_i};

    assign rx_valid_o = 1'b0;
    assign rx_data_o  = 8'h00;
    assign rx_fe_o    = 1'b0;
`endif

    assign u_sel_o     = r_sel;
    assign u_we_o      = r_we;
    assign u_addr_o    = r_addr;
    assign u_data_o    = r_wdata;
    assign tx0_ready_o = r_rdy0;
    assign tx1_ready_o = r_rdy1;
    assign init_done_o = r_init_done;

    // Sequencer: state, registered bus strobes, grant pulses and rx holding register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_INIT;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 2'd0;
            r_wdata     <= 32'd0;
            r_rdy0      <= 1'b0;
            r_rdy1      <= 1'b0;
            r_rr_last   <= 1'b1;
            r_init_done <= 1'b0;
`ifdef UART_SCHED_RX_EN
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_fe     <= 1'b0;
            r_sr_fe     <= 1'b0;
`endif
        end else begin
            // Strobes and ready pulses last one cycle unless re-armed below.
            r_sel  <= 1'b0;
            r_we   <= 1'b0;
            r_rdy0 <= 1'b0;
            r_rdy1 <= 1'b0;
`ifdef UART_SCHED_RX_EN
            if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
`endif
            case (r_state)
                ST_INIT: begin
                    r_sel       <= 1'b1;
                    r_we        <= 1'b1;
                    r_addr      <= A_BSR;
                    r_wdata     <= BAUD_DIV;
                    r_init_done <= 1'b1;
                    r_state     <= ST_BSR;
                end
                ST_BSR, ST_GAP: begin
                    r_sel   <= 1'b1;
                    r_addr  <= A_SR;
                    r_state <= ST_POLL;
                end
                ST_POLL: begin
                    r_state <= ST_WSR;
                end
                ST_WSR: begin
`ifdef UART_SCHED_RX_EN
                    if (w_sr_rx && !r_rx_valid) begin
                        r_sr_fe <= u_data_i[2];
                        r_sel   <= 1'b1;
                        r_addr  <= A_IDR;
                        r_state <= ST_RDI;
                    end else
`endif
                    if (!w_sr_busy && w_any_tx) begin
                        r_sel     <= 1'b1;
                        r_we      <= 1'b1;
                        r_addr    <= A_ODR;
                        r_wdata   <= {24'd0, w_grant_data};
                        r_rdy0    <= ~w_grant;
                        r_rdy1    <= w_grant;
                        r_rr_last <= w_grant;
                        r_state   <= ST_WR;
                    end else begin
                        r_sel   <= 1'b1;
                        r_addr  <= A_SR;
                        r_state <= ST_POLL;
                    end
                end
`ifdef UART_SCHED_RX_EN
                ST_RDI: begin
                    r_state <= ST_WIDR;
                end
                ST_WIDR: begin
                    r_rx_data  <= u_data_i[7:0];
                    r_rx_fe    <= r_sr_fe;
                    r_rx_valid <= 1'b1;
                    r_sel      <= 1'b1;
                    r_we       <= 1'b1;
                    r_addr     <= A_SR;
                    r_wdata    <= 32'd0;
                    r_state    <= ST_CLR;
                end
                ST_CLR: begin
                    r_state <= ST_GAP;
                end
`endif
                ST_WR: begin
                    r_state <= ST_GAP;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_sched.sv
// Bench for uart_bus_sched: a behavioural UART register model, two queue-driven
// requesters and an rx sink, all advanced one clock at a time by step().
module tb_uart_bus_sched;

    logic        clk_i;
    logic        rst_i;
    logic        u_sel_o;
    logic        u_we_o;
    logic [1:0]  u_addr_o;
    logic [31:0] u_data_o;
    logic [31:0] u_data_i;
    logic        tx0_valid_i;
    logic [7:0]  tx0_data_i;
    logic        tx0_ready_o;
    logic        tx1_valid_i;
    logic [7:0]  tx1_data_i;
    logic        tx1_ready_o;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_fe_o;
    logic        rx_ready_i;
    logic        init_done_o;

    uart_bus_sched #(.BAUD_DIV(32'd5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .u_sel_o     (u_sel_o),
        .u_we_o      (u_we_o),
        .u_addr_o    (u_addr_o),
        .u_data_o    (u_data_o),
        .u_data_i    (u_data_i),
        .tx0_valid_i (tx0_valid_i),
        .tx0_data_i  (tx0_data_i),
        .tx0_ready_o (tx0_ready_o),
        .tx1_valid_i (tx1_valid_i),
        .tx1_data_i  (tx1_data_i),
        .tx1_ready_o (tx1_ready_o),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .rx_fe_o     (rx_fe_o),
        .rx_ready_i  (rx_ready_i),
        .init_done_o (init_done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // UART model state
    int          busy_cnt   = 0;
    int          busy_len   = 0;
    int          force_busy = 0;
    logic        sr_rx      = 1'b0;
    logic        sr_fe      = 1'b0;
    logic [7:0]  idr        = 8'h00;
    logic [2:0]  last_sr    = 3'd0;
    int          n_idr_reads = 0;
    int          n_clr      = 0;
    logic [31:0] bsr_val    = 32'd0;

    // Requesters, arbitration reference and rx expectations
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  odr_log[$];
    logic [8:0]  rx_exp[$];
    logic        rr_model   = 1'b1;
    bit          rx_rand_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_tx();
        tx0_valid_i = (q0.size() > 0);
        tx0_data_i  = (q0.size() > 0) ? q0[0] : 8'h00;
        tx1_valid_i = (q1.size() > 0);
        tx1_data_i  = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    // Observe the current cycle, check it, then advance one clock and apply
    // the UART / requester / sink reactions to what was on the bus.
    task automatic step();
        logic        s_sel, s_we, s_r0, s_r1, s_rxv, s_fe, s_rrdy, g, busy;
        logic [1:0]  s_addr;
        logic [31:0] s_data;
        logic [7:0]  s_rxd, exp_d;
        s_sel = u_sel_o;   s_we = u_we_o;   s_addr = u_addr_o;  s_data = u_data_o;
        s_r0 = tx0_ready_o; s_r1 = tx1_ready_o;
        s_rxv = rx_valid_o; s_rxd = rx_data_o; s_fe = rx_fe_o;  s_rrdy = rx_ready_i;

        if (s_sel && s_we && s_addr == 2'd0) begin
            chk("grant_has_valid", {31'd0, tx0_valid_i | tx1_valid_i}, 32'd1);
            g     = (tx0_valid_i && tx1_valid_i) ? ~rr_model : tx1_valid_i;
            exp_d = g ? ((q1.size() > 0) ? q1[0] : 8'h00) : ((q0.size() > 0) ? q0[0] : 8'h00);
            chk("odr_data", s_data, {24'd0, exp_d});
            chk("odr_ready", {30'd0, s_r1, s_r0}, g ? 32'd2 : 32'd1);
            chk("odr_not_busy", {31'd0, last_sr[0]}, 32'd0);
            rr_model = g;
            odr_log.push_back(s_data[7:0]);
        end else if (s_r0 || s_r1) begin
            chk("stray_ready", {30'd0, s_r1, s_r0}, 32'd0);
        end
        if (!s_sel && s_we) chk("we_without_sel", {31'd0, s_we}, 32'd0);
`ifdef UART_SCHED_RX_EN
        if (s_rxv && s_rrdy) begin
            chk("rx_expected", {31'd0, rx_exp.size() > 0}, 32'd1);
            if (rx_exp.size() > 0) begin
                chk("rx_byte", {23'd0, s_fe, s_rxd}, {23'd0, rx_exp[0]});
                void'(rx_exp.pop_front());
            end
        end
`else
        if (s_rxv || s_fe || s_rxd != 8'h00)
            chk("rx_tied", {22'd0, s_rxv, s_fe, s_rxd}, 32'd0);
`endif

        @(posedge clk_i);
        #1;

        busy = (busy_cnt > 0) || (force_busy > 0);
        if (s_sel && !s_we) begin
            if (s_addr == 2'd3) begin
                u_data_i = {29'd0, sr_fe, sr_rx, busy};
                last_sr  = {sr_fe, sr_rx, busy};
                if (force_busy > 0) force_busy--;
            end else if (s_addr == 2'd1) begin
                u_data_i = {24'd0, idr};
                n_idr_reads++;
            end else begin
                u_data_i = 32'd0;
            end
        end
        if (busy_cnt > 0) busy_cnt--;
        if (s_sel && s_we) begin
            if (s_addr == 2'd0) busy_cnt = busy_len;
            if (s_addr == 2'd2) bsr_val = s_data;
            if (s_addr == 2'd3) begin
                sr_rx = 1'b0;
                sr_fe = 1'b0;
                n_clr++;
            end
        end
        if (s_r0 && q0.size() > 0) void'(q0.pop_front());
        if (s_r1 && q1.size() > 0) void'(q1.pop_front());
        refresh_tx();
        if (rx_rand_en) begin
            if (!sr_rx && $urandom_range(0, 7) == 0) begin
                idr   = 8'($urandom);
                sr_fe = 1'($urandom);
                sr_rx = 1'b1;
                rx_exp.push_back({sr_fe, idr});
            end
            rx_ready_i = 1'($urandom);
        end
    endtask

    task automatic wait_access(input string tag, input logic we, input logic [1:0] addr, input int max);
        int k;
        k = 0;
        while (!(u_sel_o && u_we_o == we && u_addr_o == addr) && k < max) begin
            step();
            k++;
        end
        chk(tag, {31'd0, u_sel_o && u_we_o == we && u_addr_o == addr}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus"}, {u_sel_o, u_we_o, u_addr_o, 28'd0}, 32'd0);
        chk({tag, "_wdata"}, u_data_o, 32'd0);
        chk({tag, "_misc"}, {26'd0, tx0_ready_o, tx1_ready_o, rx_valid_o, rx_fe_o, init_done_o, 1'b0}, 32'd0);
        chk({tag, "_rxdata"}, {24'd0, rx_data_o}, 32'd0);
    endtask

    initial begin
        int base, k, n0, n1, w0, r0;
        rst_i = 1'b0; u_data_i = 32'd0; rx_ready_i = 1'b0;
        refresh_tx();

        // 1: reset state, BSR write, then first SR poll
        repeat (3) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        rst_i = 1'b1;
        wait_access("t1_bsr_seen", 1'b1, 2'd2, 10);
        chk("t1_bsr_data", u_data_o, 32'd5);
        chk("t1_init_done", {31'd0, init_done_o}, 32'd1);
        step();
        chk("t1_poll", {29'd0, u_sel_o, u_we_o, u_addr_o} & 32'hF, 32'h3 | 32'h8);
        chk("t1_bsr_model", bsr_val, 32'd5);

        // 2: single byte on channel 0, then GAP and POLL
        q0.push_back(8'h55);
        refresh_tx();
        wait_access("t2_wr_seen", 1'b1, 2'd0, 50);
        chk("t2_data", u_data_o, 32'h55);
        chk("t2_ready", {30'd0, tx1_ready_o, tx0_ready_o}, 32'd1);
        step();
        chk("t2_gap", {31'd0, u_sel_o}, 32'd0);
        step();
        chk("t2_poll", {29'd0, u_sel_o, u_we_o, u_addr_o}, 32'hB);

        // 3: both channels held valid; channel 0 was last served
        busy_len = 3;
        base = odr_log.size();
        q0.push_back(8'h11); q0.push_back(8'h11); q0.push_back(8'h11);
        q1.push_back(8'h22); q1.push_back(8'h22);
        refresh_tx();
        k = 0;
        while (odr_log.size() < base + 5 && k < 400) begin step(); k++; end
        chk("t3_count", odr_log.size() - base, 32'd5);
        if (odr_log.size() >= base + 5) begin
            chk("t3_w0", {24'd0, odr_log[base]},     32'h22);
            chk("t3_w1", {24'd0, odr_log[base + 1]}, 32'h11);
            chk("t3_w2", {24'd0, odr_log[base + 2]}, 32'h22);
            chk("t3_w3", {24'd0, odr_log[base + 3]}, 32'h11);
        end

        // 4: UART reports busy for a run of polls; no ODR write until clear
        busy_len = 0;
        force_busy = 14;
        repeat (4) step();
        w0 = odr_log.size();
        q1.push_back(8'h77);
        refresh_tx();
        k = 0;
        while (force_busy > 0 && k < 300) begin step(); k++; end
        chk("t4_busy_drained", force_busy, 32'd0);
        chk("t4_no_write_busy", odr_log.size() - w0, 32'd0);
        repeat (40) step();
        chk("t4_one_write", odr_log.size() - w0, 32'd1);

`ifdef UART_SCHED_RX_EN
        // 5: received byte with frame error, held while sink stalls
        idr = 8'hA5; sr_fe = 1'b1; sr_rx = 1'b1;
        rx_exp.push_back({1'b1, 8'hA5});
        r0 = n_clr;
        k = 0;
        while (!rx_valid_o && k < 50) begin step(); k++; end
        chk("t5_rx_valid", {31'd0, rx_valid_o}, 32'd1);
        chk("t5_rx_data", {23'd0, rx_fe_o, rx_data_o}, 32'h1A5);
        repeat (3) step();
        chk("t5_clr_write", n_clr - r0, 32'd1);
        idr = 8'h3C; sr_fe = 1'b0; sr_rx = 1'b1;
        rx_exp.push_back({1'b0, 8'h3C});
        w0 = n_idr_reads;
        repeat (30) step();
        chk("t5_no_service", n_idr_reads - w0, 32'd0);
        chk("t5_held", {22'd0, rx_valid_o, rx_fe_o, rx_data_o}, 32'h3A5);
        rx_ready_i = 1'b1;
        step();
        rx_ready_i = 1'b0;
        chk("t5_cleared", {23'd0, rx_valid_o, rx_data_o}, 32'h0A5);
        k = 0;
        while (!rx_valid_o && k < 50) begin step(); k++; end
        chk("t5_second", {22'd0, rx_valid_o, rx_fe_o, rx_data_o}, 32'h23C);
        rx_ready_i = 1'b1;
        step();
        rx_ready_i = 1'b0;
        chk("t5_drained", rx_exp.size(), 32'd0);
`endif

        // 6: reset in the middle of an ODR write, then restart
        q0.push_back(8'h99);
        refresh_tx();
        wait_access("t6_wr_seen", 1'b1, 2'd0, 60);
        rst_i = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        step();
        step();
        rr_model = 1'b1;
        idr = 8'h5A; sr_fe = 1'b0; sr_rx = 1'b1;
`ifdef UART_SCHED_RX_EN
        rx_exp.push_back({1'b0, 8'h5A});
`endif
        rst_i = 1'b1;
        wait_access("t6_bsr_first", 1'b1, 2'd2, 10);
        step();
        chk("t6_poll", {29'd0, u_sel_o, u_we_o, u_addr_o}, 32'hB);
        step();
        step();
`ifdef UART_SCHED_RX_EN
        chk("t6_rdi_first", {29'd0, u_sel_o, u_we_o, u_addr_o}, 32'h9);
        wait_access("t6_wr_after", 1'b1, 2'd0, 60);
        chk("t6_wr_data", u_data_o, 32'h99);
        rx_ready_i = 1'b1;
        k = 0;
        while (rx_exp.size() > 0 && k < 60) begin step(); k++; end
        rx_ready_i = 1'b0;
        chk("t6_rx_drained", rx_exp.size(), 32'd0);
`else
        chk("t6_wr_first", {29'd0, u_sel_o, u_we_o, u_addr_o}, 32'hC);
        chk("t6_wr_data", u_data_o, 32'h99);
        step();
`endif

        // Randomized traffic on both channels with varying UART busy time
        rx_rand_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            busy_len = $urandom_range(0, 5);
            n0 = $urandom_range(1, 6);
            n1 = $urandom_range(1, 6);
            for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
            for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
            refresh_tx();
            base = odr_log.size();
            k = 0;
            while ((q0.size() + q1.size()) > 0 && k < 1500) begin step(); k++; end
            chk("rand_drain", q0.size() + q1.size(), 32'd0);
            chk("rand_count", odr_log.size() - base, n0 + n1);
        end
        rx_rand_en = 1'b0;
`ifdef UART_SCHED_RX_EN
        rx_ready_i = 1'b1;
        k = 0;
        while ((rx_exp.size() > 0 || sr_rx) && k < 400) begin step(); k++; end
        rx_ready_i = 1'b0;
        chk("rand_rx_drained", rx_exp.size(), 32'd0);
`else
        chk("no_idr_reads", n_idr_reads, 32'd0);
        chk("no_sr_writes", n_clr, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
